// File: rtl/pwm_multi_ctrl_if.sv
// Command stream for pwm_multi_ctrl: {ch, dir, duty} words with valid/ready.
interface pwm_multi_ctrl_if #(
  parameter int CMD_W = 11
) ();
  logic [CMD_W-1:0] in_data;
  logic             in_valid;
  logic             in_rdy;

  modport master (output in_data, output in_valid, input in_rdy);
  modport slave  (input in_data, input in_valid, output in_rdy);
endinterface

// File: rtl/pwm_multi_ctrl.sv
// N-channel speed/direction PWM generator fed by a valid/ready command stream.
// A single command register feeds per-channel shadow registers; shadows are
// applied only at a period wrap, and a direction change inserts DEAD_PERIODS
// full periods with spd held low before the new direction and duty take over.
module pwm_multi_ctrl #(
  parameter int NUM_CH       = 3,
  parameter int DUTY_W       = 8,
  parameter int PRESCALE     = 250,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              clk,
  input  logic              rst,
  pwm_multi_ctrl_if.slave   cmd_if,
  output logic [NUM_CH-1:0] spd,
  output logic [NUM_CH-1:0] dir,
  output logic              period_start,
  output logic              busy,
  output logic              err_drop
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CH_W1 = CH_W + 1;
  localparam int CMD_W = CH_W + 1 + DUTY_W;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DC_W  = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

  localparam logic [DUTY_W-1:0] CNT_MAX   = DUTY_W'((1 << DUTY_W) - 2);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [DC_W-1:0]   DEAD_INIT = DC_W'(DEAD_PERIODS);
  localparam logic [CH_W:0]     NUM_CH_L  = CH_W1'(NUM_CH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } ch_state_e;

  // Timebase
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              period_start_q, period_start_d;
  logic              tick, wrap;

  // Command register
  logic              cmd_full_q, cmd_full_d;
  logic [CH_W-1:0]   cmd_ch_q, cmd_ch_d;
  logic              cmd_dir_q, cmd_dir_d;
  logic [DUTY_W-1:0] cmd_duty_q, cmd_duty_d;
  logic              err_drop_q, err_drop_d;
  logic [CMD_W-1:0]  in_word;
  logic [CH_W-1:0]   in_ch;
  logic              in_dir;
  logic [DUTY_W-1:0] in_duty;
  logic              accept;
  logic [NUM_CH-1:0] xfer;

  // Per-channel shadow and active state
  logic [NUM_CH-1:0] shadow_full_q, shadow_full_d;
  logic [NUM_CH-1:0] shadow_dir_q, shadow_dir_d;
  logic [DUTY_W-1:0] shadow_duty_q [NUM_CH];
  logic [DUTY_W-1:0] shadow_duty_d [NUM_CH];
  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [DC_W-1:0]   dead_cnt_q [NUM_CH];
  logic [DC_W-1:0]   dead_cnt_d [NUM_CH];
  logic [DUTY_W-1:0] duty_act_q [NUM_CH];
  logic [DUTY_W-1:0] duty_act_d [NUM_CH];
  logic [NUM_CH-1:0] dir_q, dir_d;
  logic [NUM_CH-1:0] spd_q, spd_d;
  logic [NUM_CH-1:0] in_dead;

  assign in_word = cmd_if.in_data;
  assign {in_ch, in_dir, in_duty} = in_word;
  assign accept  = cmd_if.in_valid && !cmd_full_q;

  assign cmd_if.in_rdy = !cmd_full_q;
  assign spd           = spd_q;
  assign dir           = dir_q;
  assign period_start  = period_start_q;
  assign err_drop      = err_drop_q;
  assign busy          = cmd_full_q | (|shadow_full_q) | (|in_dead);

  // Tick prescaler and period counter; wrap is the last tick of a period.
  always_comb begin
    tick           = (pre_cnt_q == PRE_LAST);
    wrap           = tick && (cnt_q == CNT_MAX);
    pre_cnt_d      = tick ? '0 : pre_cnt_q + PRE_W'(1);
    cnt_d          = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + DUTY_W'(1);
    end
    period_start_d = wrap;
  end

  // Command register: accept when empty, drop bad channels, hand off to a free shadow.
  always_comb begin
    cmd_full_d = cmd_full_q;
    cmd_ch_d   = cmd_ch_q;
    cmd_dir_d  = cmd_dir_q;
    cmd_duty_d = cmd_duty_q;
    err_drop_d = 1'b0;
    xfer       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd_full_q && (cmd_ch_q == CH_W'(i)) && !shadow_full_q[i]) begin
        xfer[i] = 1'b1;
      end
    end
    if (|xfer) begin
      cmd_full_d = 1'b0;
    end
    // in_rdy is !cmd_full, so an accept never coincides with a hand-off.
    if (accept) begin
      if ({1'b0, in_ch} >= NUM_CH_L) begin
        err_drop_d = 1'b1;
      end else begin
        cmd_full_d = 1'b1;
        cmd_ch_d   = in_ch;
        cmd_dir_d  = in_dir;
        cmd_duty_d = in_duty;
      end
    end
  end

  // Flag channels currently holding spd low for a direction reversal.
  always_comb begin
    in_dead = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_dead[i] = (state_q[i] == ST_DEAD);
    end
  end

  // Per-channel RUN/DEAD next state, shadow updates and registered PWM compare.
  always_comb begin
    state_d       = state_q;
    dead_cnt_d    = dead_cnt_q;
    duty_act_d    = duty_act_q;
    dir_d         = dir_q;
    shadow_full_d = shadow_full_q;
    shadow_dir_d  = shadow_dir_q;
    shadow_duty_d = shadow_duty_q;
    spd_d         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // A duty of all-ones exceeds CNT_MAX, so that channel stays high.
      spd_d[i] = (state_q[i] == ST_RUN) && (cnt_q < duty_act_q[i]);

      // Hand-off only targets an empty shadow; wrap only clears a full one.
      if (xfer[i]) begin
        shadow_full_d[i] = 1'b1;
        shadow_dir_d[i]  = cmd_dir_q;
        shadow_duty_d[i] = cmd_duty_q;
      end

      if (wrap) begin
        if (state_q[i] == ST_DEAD) begin
          if (dead_cnt_q[i] > DC_W'(1)) begin
            dead_cnt_d[i] = dead_cnt_q[i] - DC_W'(1);
          end else begin
            dir_d[i]         = shadow_dir_q[i];
            duty_act_d[i]    = shadow_duty_q[i];
            shadow_full_d[i] = 1'b0;
            dead_cnt_d[i]    = '0;
            state_d[i]       = ST_RUN;
          end
        end else if (shadow_full_q[i]) begin
          if ((shadow_dir_q[i] == dir_q[i]) || (DEAD_PERIODS == 0)) begin
            dir_d[i]         = shadow_dir_q[i];
            duty_act_d[i]    = shadow_duty_q[i];
            shadow_full_d[i] = 1'b0;
          end else begin
            // Shadow is kept through DEAD and applied when the count expires.
            state_d[i]    = ST_DEAD;
            dead_cnt_d[i] = DEAD_INIT;
          end
        end
      end
    end
  end

  // State registers; everything returns to zero on reset, pending commands included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      cmd_full_q     <= 1'b0;
      cmd_ch_q       <= '0;
      cmd_dir_q      <= 1'b0;
      cmd_duty_q     <= '0;
      err_drop_q     <= 1'b0;
      shadow_full_q  <= '0;
      shadow_dir_q   <= '0;
      dir_q          <= '0;
      spd_q          <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_duty_q[i] <= '0;
        state_q[i]       <= ST_RUN;
        dead_cnt_q[i]    <= '0;
        duty_act_q[i]    <= '0;
      end
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      cmd_full_q     <= cmd_full_d;
      cmd_ch_q       <= cmd_ch_d;
      cmd_dir_q      <= cmd_dir_d;
      cmd_duty_q     <= cmd_duty_d;
      err_drop_q     <= err_drop_d;
      shadow_full_q  <= shadow_full_d;
      shadow_dir_q   <= shadow_dir_d;
      dir_q          <= dir_d;
      spd_q          <= spd_d;
      shadow_duty_q  <= shadow_duty_d;
      state_q        <= state_d;
      dead_cnt_q     <= dead_cnt_d;
      duty_act_q     <= duty_act_d;
    end
  end

endmodule
